// File: rtl/ethernet_tx_framer.sv
// Transmit Ethernet framer: preamble/SFD, payload, optional zero pad, CRC-32 FCS and inter-frame gap.
// Define ETHERNET_TX_PAD_EN to pad payloads shorter than 60 bytes with zeros before the FCS.

module ethernet_tx_framer #(
   parameter int IFG_BYTES = 12
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   input  logic       i_last,
   output logic       o_ready,
   output logic [7:0] o_gmii_data,
   output logic       o_gmii_enable,
   output logic       o_gmii_error,
   output logic       o_busy
);

`ifdef ETHERNET_TX_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   localparam logic [15:0] MIN_BODY = 16'd60;
   localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES);
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_SFD,
      S_PAYLOAD,
      S_PAD,
      S_FCS,
      S_IFG,
      S_DRAIN
   } state_t;

   state_t      state, state_n;
   logic [2:0]  pre_cnt, pre_cnt_n;
   logic [1:0]  fcs_idx, fcs_idx_n;
   logic [7:0]  ifg_cnt, ifg_cnt_n;
   logic [15:0] byte_cnt, byte_cnt_n;
   logic [31:0] crc, crc_n;
   logic [31:0] fcs_word;
   logic [7:0]  data_n;
   logic        en_n;
   logic        er_n;

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign o_ready  = (state == S_SFD) || (state == S_PAYLOAD) || (state == S_DRAIN);
   assign o_busy   = (state != S_IDLE);
   assign fcs_word = ~crc;

   // Next-state decode; the GMII byte loaded here appears on the pins in the following cycle
   always_comb begin
      state_n    = state;
      pre_cnt_n  = pre_cnt;
      fcs_idx_n  = fcs_idx;
      ifg_cnt_n  = ifg_cnt;
      byte_cnt_n = byte_cnt;
      crc_n      = crc;
      data_n     = 8'h00;
      en_n       = 1'b0;
      er_n       = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_valid) begin
               state_n    = S_PREAMBLE;
               pre_cnt_n  = 3'd0;
               byte_cnt_n = 16'd0;
               crc_n      = CRC_INIT;
               data_n     = 8'h55;
               en_n       = 1'b1;
            end
         end
         S_PREAMBLE: begin
            en_n = 1'b1;
            if (pre_cnt == 3'd6) begin
               data_n  = 8'hD5;
               state_n = S_SFD;
            end else begin
               data_n    = 8'h55;
               pre_cnt_n = pre_cnt + 3'd1;
            end
         end
         S_SFD, S_PAYLOAD: begin
            en_n = 1'b1;
            if (i_valid) begin
               data_n     = i_data;
               crc_n      = crc32_byte(crc, i_data);
               byte_cnt_n = sat_inc16(byte_cnt);
               if (i_last) begin
                  fcs_idx_n = 2'd0;
                  state_n   = (PAD_EN && (byte_cnt_n < MIN_BODY)) ? S_PAD : S_FCS;
               end else begin
                  state_n = S_PAYLOAD;
               end
            end else begin
               // Source starved mid-frame: poison the frame and swallow the rest of it
               er_n    = 1'b1;
               state_n = S_DRAIN;
            end
         end
         S_PAD: begin
            en_n       = 1'b1;
            crc_n      = crc32_byte(crc, 8'h00);
            byte_cnt_n = sat_inc16(byte_cnt);
            if (byte_cnt_n >= MIN_BODY) begin
               fcs_idx_n = 2'd0;
               state_n   = S_FCS;
            end
         end
         S_FCS: begin
            en_n      = 1'b1;
            fcs_idx_n = fcs_idx + 2'd1;
            case (fcs_idx)
               2'd0:    data_n = fcs_word[7:0];
               2'd1:    data_n = fcs_word[15:8];
               2'd2:    data_n = fcs_word[23:16];
               default: data_n = fcs_word[31:24];
            endcase
            if (fcs_idx == 2'd3) begin
               ifg_cnt_n = 8'd0;
               state_n   = S_IFG;
            end
         end
         S_IFG: begin
            // The final IFG cycle launches the next preamble byte, so the idle gap is exactly IFG_BYTES
            if (ifg_cnt == IFG_LAST) begin
               if (i_valid) begin
                  state_n    = S_PREAMBLE;
                  pre_cnt_n  = 3'd0;
                  byte_cnt_n = 16'd0;
                  crc_n      = CRC_INIT;
                  data_n     = 8'h55;
                  en_n       = 1'b1;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               ifg_cnt_n = ifg_cnt + 8'd1;
            end
         end
         S_DRAIN: begin
            if (i_valid && i_last) begin
               ifg_cnt_n = 8'd0;
               state_n   = S_IFG;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State and registered GMII outputs
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= S_IDLE;
         pre_cnt       <= 3'd0;
         fcs_idx       <= 2'd0;
         ifg_cnt       <= 8'd0;
         byte_cnt      <= 16'd0;
         crc           <= CRC_INIT;
         o_gmii_data   <= 8'h00;
         o_gmii_enable <= 1'b0;
         o_gmii_error  <= 1'b0;
      end else begin
         state         <= state_n;
         pre_cnt       <= pre_cnt_n;
         fcs_idx       <= fcs_idx_n;
         ifg_cnt       <= ifg_cnt_n;
         byte_cnt      <= byte_cnt_n;
         crc           <= crc_n;
         o_gmii_data   <= data_n;
         o_gmii_enable <= en_n;
         o_gmii_error  <= er_n;
      end
   end

endmodule

// File: tb/tb_ethernet_tx_framer.sv
// Self-checking bench for ethernet_tx_framer: directed and random frames against a frame-level reference model.
// Honours ETHERNET_TX_PAD_EN the same way the design does.

module tb_ethernet_tx_framer;

   localparam int IFG = 12;

`ifdef ETHERNET_TX_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din;
   logic       vld;
   logic       lst;
   logic       rdy;
   logic [7:0] gdata;
   logic       gen;
   logic       ger;
   logic       busy;

   ethernet_tx_framer #(.IFG_BYTES(IFG)) dut (
      .i_clock       (clk),
      .i_reset_n     (rst_n),
      .i_data        (din),
      .i_valid       (vld),
      .i_last        (lst),
      .o_ready       (rdy),
      .o_gmii_data   (gdata),
      .o_gmii_enable (gen),
      .o_gmii_error  (ger),
      .o_busy        (busy)
   );

   always #4 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [31:0] crc_tab [256];
   logic [7:0]  pay [$];
   logic [8:0]  exp_q [$];
   int          exp_len_q [$];
   logic [7:0]  last_frame [$];
   logic [7:0]  cur_frame [$];
   int          last_len = 0;
   int          last_gap = -1;
   int          rdy_cnt = 0;
   int          cur_len = 0;
   int          low_cnt = 0;
   bit          prev_en = 1'b0;
   bit          have_prev = 1'b0;

   // Expected wire image of one frame, built from the framing rules
   task automatic push_expect(input int under_k);
      logic [7:0]  body [$];
      logic [31:0] c;
      repeat (7) exp_q.push_back(9'h055);
      exp_q.push_back(9'h0D5);
      if (under_k >= 0) begin
         for (int k = 0; k < under_k; k++) exp_q.push_back({1'b0, pay[k]});
         exp_q.push_back(9'h100);
         exp_len_q.push_back(9 + under_k);
      end else begin
         body = pay;
         if (PAD_EN) while (body.size() < 60) body.push_back(8'h00);
         c = 32'hFFFF_FFFF;
         foreach (body[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ body[i]];
         c = ~c;
         foreach (body[i]) exp_q.push_back({1'b0, body[i]});
         for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
         exp_len_q.push_back(8 + body.size() + 4);
      end
   endtask

   // Output monitor: compares the GMII stream byte by byte and measures frame length and gap
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_len_q.delete();
         cur_frame.delete();
         prev_en   = 1'b0;
         have_prev = 1'b0;
         cur_len   = 0;
         low_cnt   = 0;
      end else begin
         if (rdy) rdy_cnt++;
         if (gen) begin
            if (!prev_en && have_prev) last_gap = low_cnt;
            low_cnt = 0;
            cur_len++;
            cur_frame.push_back(gdata);
            check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("byte", 32'({ger, gdata}), 32'(exp_q.pop_front()));
         end else begin
            if (prev_en) begin
               last_len   = cur_len;
               last_frame = cur_frame;
               cur_frame.delete();
               have_prev  = 1'b1;
               check("frame_expected", 32'(exp_len_q.size() > 0), 32'd1);
               if (exp_len_q.size() > 0) check("frame_len", cur_len, exp_len_q.pop_front());
               cur_len = 0;
            end
            low_cnt++;
         end
         prev_en = gen;
      end
   end

   task automatic send_frame(input int under_k, input int abort_k, input bit keep_valid);
      int  idx = 0;
      int  cyc = 0;
      int  n;
      bit  dropped = 1'b0;
      bit  hs;
      n = pay.size();
      push_expect(under_k);
      while (idx < n && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         din = pay[idx];
         lst = (idx == n - 1);
         if (abort_k >= 0 && idx == abort_k) begin
            vld = 1'b1;
            check("pre_rst_enable", 32'(gen), 32'd1);
            rst_n = 1'b0;
            #1;
            check("rst_enable", 32'(gen), 32'd0);
            check("rst_ready", 32'(rdy), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_data", 32'(gdata), 32'd0);
            vld = 1'b0;
            lst = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (under_k >= 0 && !dropped && idx == under_k && rdy) begin
            vld     = 1'b0;
            dropped = 1'b1;
         end else begin
            vld = 1'b1;
         end
         hs = vld && rdy;
         @(posedge clk);
         if (hs) idx++;
      end
      check("send_done", idx, n);
      if (!keep_valid) begin
         @(negedge clk);
         vld = 1'b0;
         lst = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || exp_len_q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", 32'(n < 3000), 32'd1);
      check("exp_drained", exp_q.size(), 0);
      @(negedge clk);
   endtask

   task automatic load_counting();
      pay.delete();
      for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int len;
      int uk;
      bit kv;
      for (int i = 0; i < 256; i++) begin
         logic [31:0] c;
         c = 32'(i);
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         crc_tab[i] = c;
      end

      rst_n = 1'b0;
      vld   = 1'b0;
      lst   = 1'b0;
      din   = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_data", 32'(gdata), 32'd0);
      check("reset_enable", 32'(gen), 32'd0);
      check("reset_error", 32'(ger), 32'd0);
      check("reset_ready", 32'(rdy), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // "123456789"
      load_counting();
      send_frame(-1, -1, 1'b0);
      wait_idle();
`ifdef ETHERNET_TX_PAD_EN
      check("t1_len_padded", last_len, 72);
`else
      check("t1_len", last_len, 21);
      check("t1_fcs0", 32'(last_frame[17]), 32'h26);
      check("t1_fcs1", 32'(last_frame[18]), 32'h39);
      check("t1_fcs2", 32'(last_frame[19]), 32'hF4);
      check("t1_fcs3", 32'(last_frame[20]), 32'hCB);
`endif

      // Single-byte payload
      pay = '{8'hAB};
      send_frame(-1, -1, 1'b0);
      wait_idle();
      check("t2_first_byte", 32'(last_frame[8]), 32'hAB);
`ifdef ETHERNET_TX_PAD_EN
      check("t2_len_padded", last_len, 72);
`else
      check("t2_len", last_len, 13);
`endif

      // 60-byte payload needs no padding in either build
      pay.delete();
      for (int i = 0; i < 60; i++) pay.push_back(8'(i));
      rdy_cnt = 0;
      send_frame(-1, -1, 1'b0);
      wait_idle();
      check("t3_len", last_len, 72);
      check("t3_ready_cycles", rdy_cnt, 60);

      // Underrun after 10 payload bytes
      pay.delete();
      for (int i = 0; i < 30; i++) pay.push_back(8'($urandom));
      send_frame(10, -1, 1'b0);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("t4_drain_ifg", 32'(n >= IFG && n <= IFG + 1), 32'd1);
      wait_idle();
      check("t4_len", last_len, 19);

      // Back-to-back frames with i_valid held high
      pay.delete();
      for (int i = 0; i < 20; i++) pay.push_back(8'($urandom));
      send_frame(-1, -1, 1'b1);
      pay.delete();
      for (int i = 0; i < 15; i++) pay.push_back(8'($urandom));
      send_frame(-1, -1, 1'b0);
      wait_idle();
      check("t5_gap", last_gap, IFG);

      // Reset pulse during payload byte 20, then a clean frame
      pay.delete();
      for (int i = 0; i < 40; i++) pay.push_back(8'($urandom));
      send_frame(-1, 20, 1'b0);
      #1;
      check("t6_post_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      load_counting();
      send_frame(-1, -1, 1'b0);
      wait_idle();
`ifdef ETHERNET_TX_PAD_EN
      check("t6_len_padded", last_len, 72);
`else
      check("t6_fcs0", 32'(last_frame[17]), 32'h26);
      check("t6_fcs3", 32'(last_frame[20]), 32'hCB);
`endif

      // Random frames, occasional underruns and back-to-back starts
      for (int f = 0; f < 10; f++) begin
         len = $urandom_range(1, 80);
         pay.delete();
         for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
         uk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
         kv = ($urandom_range(0, 2) == 0) && (f != 9);
         send_frame(uk, -1, kv);
         if (!kv) repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
